// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter_if                                        |
// | Brief    : Requester, stall and decoder-side signals of the write arbiter. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5,
    parameter int NUM_REGS   = 32
);
    logic                  a_req;
    logic [ADDR_BITS-1:0]  a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_gnt;
    logic                  b_req;
    logic [ADDR_BITS-1:0]  b_addr;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_gnt;
    logic                  wr_stall;
    logic                  wr_ld;
    logic [ADDR_BITS-1:0]  wr_sel;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_REGS-1:0]   pend;
    logic                  collide;

    // Master is the surrounding pipeline: requesters plus the register file.
    modport master (
        output a_req, a_addr, a_data, b_req, b_addr, b_data, wr_stall,
        input  a_gnt, b_gnt, wr_ld, wr_sel, wr_data, pend, collide
    );

    modport slave (
        input  a_req, a_addr, a_data, b_req, b_addr, b_data, wr_stall,
        output a_gnt, b_gnt, wr_ld, wr_sel, wr_data, pend, collide
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter                                           |
// | Brief    : Round-robin arbiter sharing the register-file write port        |
// |            between ALU and load writeback, with a one-entry output stage.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5,
    parameter int NUM_REGS   = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    regfile_write_arbiter_if.slave  bus
);

    logic                  r_out_valid;
    logic [ADDR_BITS-1:0]  r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_last_b;
    logic                  r_collide;

    logic                  w_can_acc;
    logic                  w_contest;
    logic                  w_a_gnt;
    logic                  w_b_gnt;
    logic                  w_gnt;
    logic                  w_drain;
    logic [ADDR_BITS-1:0]  w_gnt_addr;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    // A full stage that drains this cycle can be refilled in the same cycle.
    assign w_can_acc = !r_out_valid || !bus.wr_stall;
    assign w_contest = bus.a_req && bus.b_req;
    assign w_drain   = r_out_valid && !bus.wr_stall;

    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (w_can_acc) begin
            if (bus.a_req && (!bus.b_req || r_last_b)) begin
                w_a_gnt = 1'b1;
            end else if (bus.b_req) begin
                w_b_gnt = 1'b1;
            end
        end
    end

    assign w_gnt      = w_a_gnt || w_b_gnt;
    assign w_gnt_addr = w_a_gnt ? bus.a_addr : bus.b_addr;
    assign w_gnt_data = w_a_gnt ? bus.a_data : bus.b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_last_b    <= 1'b1;
            r_collide   <= 1'b0;
        end else begin
            if (w_gnt && w_contest) begin
                r_last_b <= w_b_gnt;
            end
            // Writes to %g0 are granted but never reach the register file.
            if (w_gnt && (w_gnt_addr != '0)) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= w_gnt_addr;
                r_out_data  <= w_gnt_data;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            r_collide <= w_contest && (bus.a_addr == bus.b_addr) && (bus.a_addr != '0);
        end
    end

    assign bus.a_gnt   = w_a_gnt;
    assign bus.b_gnt   = w_b_gnt;
    assign bus.wr_ld   = r_out_valid;
    assign bus.wr_sel  = r_out_addr;
    assign bus.wr_data = r_out_data;
    assign bus.collide = r_collide;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
        assign bus.pend[i] = r_out_valid && (r_out_addr == ADDR_BITS'(i));
    end

endmodule
`default_nettype wire
